// File: rtl/decode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : decode_sequencer
//  Description : Top-level decode flow sequencer (UART load -> milestone2 ->
//                milestone1 -> VGA) and single-port SRAM grant arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_sequencer #(
    parameter logic [25:0] UART_TIMEOUT  = 26'd49999999,
    parameter logic [31:0] STAGE_TIMEOUT = 32'd0,
    parameter logic        SKIP_UART     = 1'b0
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start_i,
    input  logic        uart_rx_line_i,
    input  logic        uart_we_n_i,
    input  logic [17:0] uart_address_i,
    input  logic [15:0] uart_write_data_i,
    output logic        uart_rx_initialize_o,
    output logic        uart_rx_enable_o,
    output logic        m2_start_o,
    input  logic        m2_finish_i,
    input  logic [17:0] m2_address_i,
    input  logic [15:0] m2_write_data_i,
    input  logic        m2_we_n_i,
    output logic        m1_start_o,
    input  logic        m1_finish_i,
    input  logic [17:0] m1_address_i,
    input  logic [15:0] m1_write_data_i,
    input  logic        m1_we_n_i,
    input  logic [17:0] vga_address_i,
    output logic        vga_enable_o,
    output logic [17:0] SRAM_address_o,
    output logic [15:0] SRAM_write_data_o,
    output logic        SRAM_we_n_o,
    output logic [2:0]  state_o,
    output logic        timeout_error_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UART_INIT = 3'd1,
        S_UART_RX   = 3'd2,
        S_M2_START  = 3'd3,
        S_M2_RUN    = 3'd4,
        S_M1_START  = 3'd5,
        S_M1_RUN    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [25:0] r_uart_timer;
    logic [25:0] w_uart_timer_next;
    logic        r_uart_wrote;
    logic        r_uart_init;
    logic        r_uart_enable;
    logic [31:0] r_stage_timer;
    logic        r_vga_enable;
    logic        r_timeout_error;
    logic        w_accept_start;
    logic        w_uart_done;
    logic        w_stage_expired;
    logic        w_timeout_hit;
    logic        w_finish_idle;
    logic        w_init_pulse;

    // Saturating idle counter; it is compared against its next value so the
    // load-complete transition lands exactly UART_TIMEOUT edges after a write.
    always_comb begin
        w_uart_timer_next = r_uart_timer;
        if (r_uart_init || !uart_we_n_i) begin
            w_uart_timer_next = 26'd0;
        end else if (r_uart_timer != {26{1'b1}}) begin
            w_uart_timer_next = r_uart_timer + 26'd1;
        end
    end

    assign w_uart_done     = (w_uart_timer_next == UART_TIMEOUT) && r_uart_wrote;
    assign w_stage_expired = (STAGE_TIMEOUT != 32'd0) && (r_stage_timer == STAGE_TIMEOUT);

    always_comb begin
        w_state_next   = r_state;
        w_accept_start = 1'b0;
        w_timeout_hit  = 1'b0;
        w_finish_idle  = 1'b0;
        w_init_pulse   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i || !uart_rx_line_i) begin
                    w_accept_start = 1'b1;
                    w_init_pulse   = 1'b1;
                    w_state_next   = SKIP_UART ? S_M2_START : S_UART_INIT;
                end
            end
            S_UART_INIT: w_state_next = S_UART_RX;
            S_UART_RX: begin
                if (w_uart_done) begin
                    w_init_pulse = 1'b1;
                    w_state_next = S_M2_START;
                end
            end
            S_M2_START: w_state_next = S_M2_RUN;
            // Finish is tested first so it wins over a same-cycle expiry.
            S_M2_RUN: begin
                if (m2_finish_i) begin
                    w_state_next = S_M1_START;
                end else if (w_stage_expired) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            S_M1_START: w_state_next = S_M1_RUN;
            S_M1_RUN: begin
                if (m1_finish_i) begin
                    w_finish_idle = 1'b1;
                    w_state_next  = S_IDLE;
                end else if (w_stage_expired) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state         <= S_IDLE;
            r_uart_timer    <= 26'd0;
            r_uart_wrote    <= 1'b0;
            r_uart_init     <= 1'b0;
            r_uart_enable   <= 1'b0;
            r_stage_timer   <= 32'd0;
            r_vga_enable    <= 1'b1;
            r_timeout_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_uart_timer  <= w_uart_timer_next;
            r_uart_init   <= w_init_pulse;
            r_uart_enable <= (r_state == S_UART_INIT);

            if (r_uart_init) begin
                r_uart_wrote <= 1'b0;
            end else if (!uart_we_n_i) begin
                r_uart_wrote <= 1'b1;
            end

            if (r_state == S_M2_START || r_state == S_M1_START) begin
                r_stage_timer <= 32'd0;
            end else if (r_state == S_M2_RUN || r_state == S_M1_RUN) begin
                r_stage_timer <= r_stage_timer + 32'd1;
            end

            if (w_accept_start) begin
                r_vga_enable    <= 1'b0;
                r_timeout_error <= 1'b0;
            end else if (w_finish_idle || w_timeout_hit) begin
                r_vga_enable <= 1'b1;
            end

            if (w_timeout_hit) begin
                r_timeout_error <= 1'b1;
            end
        end
    end

    // Grant follows the registered state only; hand-over states never write.
    always_comb begin
        SRAM_address_o    = vga_address_i;
        SRAM_write_data_o = 16'd0;
        SRAM_we_n_o       = 1'b1;
        case (r_state)
            S_UART_INIT, S_UART_RX: begin
                SRAM_address_o    = uart_address_i;
                SRAM_write_data_o = uart_write_data_i;
                SRAM_we_n_o       = uart_we_n_i;
            end
            S_M2_RUN: begin
                SRAM_address_o    = m2_address_i;
                SRAM_write_data_o = m2_write_data_i;
                SRAM_we_n_o       = m2_we_n_i;
            end
            S_M1_RUN: begin
                SRAM_address_o    = m1_address_i;
                SRAM_write_data_o = m1_write_data_i;
                SRAM_we_n_o       = m1_we_n_i;
            end
            default: begin
            end
        endcase
    end

    assign uart_rx_initialize_o = r_uart_init;
    assign uart_rx_enable_o     = r_uart_enable;
    assign m2_start_o           = (r_state == S_M2_START);
    assign m1_start_o           = (r_state == S_M1_START);
    assign vga_enable_o         = r_vga_enable;
    assign state_o              = r_state;
    assign timeout_error_o      = r_timeout_error;

endmodule
`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_sequencer
//  Description : Randomized self-checking bench; instance a takes the UART
//                path with a 30-cycle watchdog, instance b skips UART.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_sequencer;

    localparam int c_UART_TO  = 20;
    localparam int c_STAGE_TO = 30;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        start_i, uart_rx_line_i, uart_we_n_i;
    logic [17:0] uart_address_i, m2_address_i, m1_address_i, vga_address_i;
    logic [15:0] uart_write_data_i, m2_write_data_i, m1_write_data_i;
    logic        m2_finish_i, m2_we_n_i, m1_finish_i, m1_we_n_i;

    logic        init_a, en_a, m2s_a, m1s_a, vga_a, we_a, err_a;
    logic        init_b, en_b, m2s_b, m1s_b, vga_b, we_b, err_b;
    logic [17:0] addr_a, addr_b;
    logic [15:0] wd_a, wd_b;
    logic [2:0]  st_a, st_b;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    decode_sequencer #(
        .UART_TIMEOUT (26'(c_UART_TO)),
        .STAGE_TIMEOUT(32'(c_STAGE_TO)),
        .SKIP_UART    (1'b0)
    ) dut_a (
        .CLOCK_50_I(clk), .Resetn(Resetn), .start_i(start_i),
        .uart_rx_line_i(uart_rx_line_i), .uart_we_n_i(uart_we_n_i),
        .uart_address_i(uart_address_i), .uart_write_data_i(uart_write_data_i),
        .uart_rx_initialize_o(init_a), .uart_rx_enable_o(en_a),
        .m2_start_o(m2s_a), .m2_finish_i(m2_finish_i), .m2_address_i(m2_address_i),
        .m2_write_data_i(m2_write_data_i), .m2_we_n_i(m2_we_n_i),
        .m1_start_o(m1s_a), .m1_finish_i(m1_finish_i), .m1_address_i(m1_address_i),
        .m1_write_data_i(m1_write_data_i), .m1_we_n_i(m1_we_n_i),
        .vga_address_i(vga_address_i), .vga_enable_o(vga_a),
        .SRAM_address_o(addr_a), .SRAM_write_data_o(wd_a), .SRAM_we_n_o(we_a),
        .state_o(st_a), .timeout_error_o(err_a)
    );

    decode_sequencer #(
        .UART_TIMEOUT (26'(c_UART_TO)),
        .STAGE_TIMEOUT(32'd0),
        .SKIP_UART    (1'b1)
    ) dut_b (
        .CLOCK_50_I(clk), .Resetn(Resetn), .start_i(start_i),
        .uart_rx_line_i(uart_rx_line_i), .uart_we_n_i(uart_we_n_i),
        .uart_address_i(uart_address_i), .uart_write_data_i(uart_write_data_i),
        .uart_rx_initialize_o(init_b), .uart_rx_enable_o(en_b),
        .m2_start_o(m2s_b), .m2_finish_i(m2_finish_i), .m2_address_i(m2_address_i),
        .m2_write_data_i(m2_write_data_i), .m2_we_n_i(m2_we_n_i),
        .m1_start_o(m1s_b), .m1_finish_i(m1_finish_i), .m1_address_i(m1_address_i),
        .m1_write_data_i(m1_write_data_i), .m1_we_n_i(m1_we_n_i),
        .vga_address_i(vga_address_i), .vga_enable_o(vga_b),
        .SRAM_address_o(addr_b), .SRAM_write_data_o(wd_b), .SRAM_we_n_o(we_b),
        .state_o(st_b), .timeout_error_o(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_buses();
        uart_address_i    = 18'($urandom);
        uart_write_data_i = 16'($urandom);
        m2_address_i      = 18'($urandom);
        m2_write_data_i   = 16'($urandom);
        m1_address_i      = 18'($urandom);
        m1_write_data_i   = 16'($urandom);
        vga_address_i     = 18'($urandom);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        start_i = 1'b0; uart_rx_line_i = 1'b1; uart_we_n_i = 1'b1;
        m2_finish_i = 1'b0; m1_finish_i = 1'b0; m2_we_n_i = 1'b1; m1_we_n_i = 1'b1;
        randomize_buses();
        repeat (3) @(posedge clk);
        #1;
        Resetn = 1'b1;
    endtask

    // Stimulus only: brings instance a into its first M2_RUN cycle.
    task automatic goto_m2_run_a();
        do_reset();
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        uart_we_n_i = 1'b0; tick(); uart_we_n_i = 1'b1;
        repeat (c_UART_TO) @(posedge clk);
        #1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            randomize_buses();
            uart_we_n_i = 1'($urandom); m2_we_n_i = 1'b0; m1_we_n_i = 1'b0;
            #1;
            n_checks++;
            if ({st_a, vga_a, we_a, init_a, en_a, m2s_a, m1s_a, err_a, addr_a, wd_a} !==
                {3'd0, 1'b1, 1'b1, 5'b0, vga_address_i, 16'd0}) begin
                n_bad++;
                $display("FAIL idle_a cyc=%0d got st=%0d vga=%b we=%b addr=%h wd=%h exp addr=%h",
                         i, st_a, vga_a, we_a, addr_a, wd_a, vga_address_i);
            end
            n_checks++;
            if ({st_b, vga_b, we_b, addr_b} !== {3'd0, 1'b1, 1'b1, vga_address_i}) begin
                n_bad++;
                $display("FAIL idle_b cyc=%0d got st=%0d vga=%b we=%b addr=%h exp addr=%h",
                         i, st_b, vga_b, we_b, addr_b, vga_address_i);
            end
            tick();
        end
        uart_we_n_i = 1'b1; m2_we_n_i = 1'b1; m1_we_n_i = 1'b1;
    endtask

    task automatic test_uart_load();
        int gap;
        int run;
        logic [2:0] exp_st;
        do_reset();
        start_i = 1'b1; tick(); start_i = 1'b0; #1;
        n_checks++;
        if ({st_a, init_a, en_a, vga_a} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL uart_init got st=%0d init=%b en=%b vga=%b exp st=1 init=1 en=0 vga=0",
                     st_a, init_a, en_a, vga_a);
        end
        tick(); #1;
        n_checks++;
        if ({st_a, init_a, en_a} !== {3'd2, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL uart_enable got st=%0d init=%b en=%b exp st=2 init=0 en=1",
                     st_a, init_a, en_a);
        end
        for (int w = 0; w < 3; w++) begin
            gap = $urandom_range(1, c_UART_TO - 5);
            for (int g = 0; g < gap; g++) begin
                tick();
                uart_we_n_i = 1'b1; randomize_buses(); #1;
                n_checks++;
                if ({st_a, we_a, addr_a, wd_a} !== {3'd2, 1'b1, uart_address_i, uart_write_data_i}) begin
                    n_bad++;
                    $display("FAIL uart_gap w=%0d got st=%0d we=%b addr=%h exp st=2 we=1 addr=%h",
                             w, st_a, we_a, addr_a, uart_address_i);
                end
            end
            tick();
            uart_we_n_i = 1'b0; uart_address_i = 18'(w); uart_write_data_i = 16'($urandom); #1;
            n_checks++;
            if ({st_a, we_a, addr_a, wd_a} !== {3'd2, 1'b0, 18'(w), uart_write_data_i}) begin
                n_bad++;
                $display("FAIL uart_write w=%0d got st=%0d we=%b addr=%h wd=%h exp we=0 addr=%h wd=%h",
                         w, st_a, we_a, addr_a, wd_a, 18'(w), uart_write_data_i);
            end
        end
        // k counts edges from the one sampling the last write.
        for (int k = 0; k <= c_UART_TO; k++) begin
            tick();
            uart_we_n_i = 1'b1; m2_we_n_i = 1'b0; m2_finish_i = (k == c_UART_TO);
            vga_address_i = 18'($urandom); #1;
            exp_st = (k == c_UART_TO) ? 3'd3 : 3'd2;
            n_checks++;
            if (st_a !== exp_st || m2s_a !== (k == c_UART_TO)) begin
                n_bad++;
                $display("FAIL uart_timeout k=%0d got st=%0d m2s=%b exp st=%0d", k, st_a, m2s_a, exp_st);
            end
        end
        n_checks++;
        if ({init_a, we_a, addr_a, wd_a} !== {1'b1, 1'b1, vga_address_i, 16'd0}) begin
            n_bad++;
            $display("FAIL m2_start_grant got init=%b we=%b addr=%h exp init=1 we=1 addr=%h",
                     init_a, we_a, addr_a, vga_address_i);
        end
        run = $urandom_range(3, 20);
        for (int c = 0; c < run; c++) begin
            tick();
            randomize_buses(); m2_we_n_i = 1'($urandom);
            m2_finish_i = (c == run - 1); m1_finish_i = 1'($urandom); #1;
            n_checks++;
            if ({st_a, m2s_a, init_a, we_a, addr_a, wd_a} !==
                {3'd4, 1'b0, 1'b0, m2_we_n_i, m2_address_i, m2_write_data_i}) begin
                n_bad++;
                $display("FAIL m2_run c=%0d got st=%0d m2s=%b we=%b addr=%h exp st=4 we=%b addr=%h",
                         c, st_a, m2s_a, we_a, addr_a, m2_we_n_i, m2_address_i);
            end
        end
        tick();
        m2_finish_i = 1'b0; m1_finish_i = 1'b1; m1_we_n_i = 1'b0; #1;
        n_checks++;
        if ({st_a, m1s_a, we_a, addr_a} !== {3'd5, 1'b1, 1'b1, vga_address_i}) begin
            n_bad++;
            $display("FAIL m1_start got st=%0d m1s=%b we=%b addr=%h exp st=5 m1s=1 we=1 addr=%h",
                     st_a, m1s_a, we_a, addr_a, vga_address_i);
        end
        run = $urandom_range(3, 20);
        for (int c = 0; c < run; c++) begin
            tick();
            randomize_buses(); m1_we_n_i = 1'($urandom);
            m1_finish_i = (c == run - 1); m2_finish_i = 1'($urandom); #1;
            n_checks++;
            if ({st_a, m1s_a, we_a, addr_a, wd_a} !==
                {3'd6, 1'b0, m1_we_n_i, m1_address_i, m1_write_data_i}) begin
                n_bad++;
                $display("FAIL m1_run c=%0d got st=%0d we=%b addr=%h exp st=6 we=%b addr=%h",
                         c, st_a, we_a, addr_a, m1_we_n_i, m1_address_i);
            end
        end
        tick();
        m1_finish_i = 1'b0; m2_finish_i = 1'b0; m1_we_n_i = 1'b1; #1;
        n_checks++;
        if ({st_a, vga_a, err_a, we_a} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL flow_done got st=%0d vga=%b err=%b we=%b exp st=0 vga=1 err=0 we=1",
                     st_a, vga_a, err_a, we_a);
        end
    endtask

    task automatic test_uart_no_write();
        do_reset();
        uart_rx_line_i = 1'b0; tick(); uart_rx_line_i = 1'b1; #1;
        n_checks++;
        if (st_a !== 3'd1) begin
            n_bad++;
            $display("FAIL rx_line_start got st=%0d exp st=1", st_a);
        end
        tick();
        for (int i = 0; i < 200; i++) begin
            tick();
            start_i = (i == 100); m2_finish_i = 1'($urandom);
            uart_rx_line_i = 1'($urandom); #1;
            n_checks++;
            if (st_a !== 3'd2 || init_a !== 1'b0) begin
                n_bad++;
                $display("FAIL uart_no_write i=%0d got st=%0d init=%b exp st=2 init=0", i, st_a, init_a);
            end
        end
        start_i = 1'b0; m2_finish_i = 1'b0; uart_rx_line_i = 1'b1;
    endtask

    task automatic test_skip_sequence();
        do_reset();
        m2_we_n_i = 1'b0;
        start_i = 1'b1; tick(); start_i = 1'b0; #1;
        n_checks++;
        if ({st_b, m2s_b, init_b, vga_b, we_b, addr_b} !==
            {3'd3, 1'b1, 1'b1, 1'b0, 1'b1, vga_address_i}) begin
            n_bad++;
            $display("FAIL skip_m2_start got st=%0d m2s=%b init=%b vga=%b we=%b exp st=3 m2s=1 init=1 vga=0 we=1",
                     st_b, m2s_b, init_b, vga_b, we_b);
        end
        for (int c = 0; c < 50; c++) begin
            tick();
            randomize_buses(); m2_we_n_i = 1'($urandom); m2_finish_i = (c == 49); #1;
            n_checks++;
            if ({st_b, we_b, addr_b, wd_b} !== {3'd4, m2_we_n_i, m2_address_i, m2_write_data_i}) begin
                n_bad++;
                $display("FAIL skip_m2_run c=%0d got st=%0d addr=%h exp st=4 addr=%h",
                         c, st_b, addr_b, m2_address_i);
            end
        end
        tick();
        m2_finish_i = 1'b0; m1_we_n_i = 1'b0; #1;
        n_checks++;
        if ({st_b, m1s_b, we_b} !== {3'd5, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL skip_m1_start got st=%0d m1s=%b we=%b exp st=5 m1s=1 we=1", st_b, m1s_b, we_b);
        end
        for (int c = 0; c < 80; c++) begin
            tick();
            randomize_buses(); m1_we_n_i = 1'($urandom); m1_finish_i = (c == 79); #1;
            n_checks++;
            if ({st_b, we_b, addr_b, wd_b} !== {3'd6, m1_we_n_i, m1_address_i, m1_write_data_i}) begin
                n_bad++;
                $display("FAIL skip_m1_run c=%0d got st=%0d addr=%h exp st=6 addr=%h",
                         c, st_b, addr_b, m1_address_i);
            end
        end
        tick();
        m1_finish_i = 1'b0; m1_we_n_i = 1'b1; m2_we_n_i = 1'b1; #1;
        n_checks++;
        if ({st_b, vga_b, addr_b, wd_b} !== {3'd0, 1'b1, vga_address_i, 16'd0}) begin
            n_bad++;
            $display("FAIL skip_done got st=%0d vga=%b addr=%h exp st=0 vga=1 addr=%h",
                     st_b, vga_b, addr_b, vga_address_i);
        end
    endtask

    task automatic test_watchdog();
        logic [4:0] exp;
        goto_m2_run_a();
        for (int c = 0; c <= c_STAGE_TO + 1; c++) begin
            if (c > 0) tick();
            #1;
            exp = (c == c_STAGE_TO + 1) ? {3'd0, 1'b1, 1'b1} : {3'd4, 1'b0, 1'b0};
            n_checks++;
            if ({st_a, err_a, vga_a} !== exp) begin
                n_bad++;
                $display("FAIL watchdog_m2 c=%0d got st/err/vga=%b exp %b", c, {st_a, err_a, vga_a}, exp);
            end
        end
        start_i = 1'b1; tick(); start_i = 1'b0; #1;
        n_checks++;
        if ({st_a, err_a} !== {3'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL watchdog_clear got st=%0d err=%b exp st=1 err=0", st_a, err_a);
        end
    endtask

    task automatic test_finish_vs_timeout();
        logic [4:0] exp;
        goto_m2_run_a();
        for (int c = 0; c <= c_STAGE_TO; c++) begin
            if (c > 0) tick();
            m2_finish_i = (c == c_STAGE_TO);
        end
        tick();
        m2_finish_i = 1'b0; #1;
        n_checks++;
        if ({st_a, err_a} !== {3'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL finish_wins got st=%0d err=%b exp st=5 err=0", st_a, err_a);
        end
        tick();
        for (int c = 0; c <= c_STAGE_TO + 1; c++) begin
            if (c > 0) tick();
            #1;
            exp = (c == c_STAGE_TO + 1) ? {3'd0, 1'b1, 1'b1} : {3'd6, 1'b0, 1'b0};
            n_checks++;
            if ({st_a, err_a, vga_a} !== exp) begin
                n_bad++;
                $display("FAIL watchdog_m1 c=%0d got st/err/vga=%b exp %b", c, {st_a, err_a, vga_a}, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        m2_finish_i = 1'b1; tick(); m2_finish_i = 1'b0;
        tick();
        m1_we_n_i = 1'b0; m1_address_i = 18'($urandom); #1;
        n_checks++;
        if ({st_b, we_b, addr_b} !== {3'd6, 1'b0, m1_address_i}) begin
            n_bad++;
            $display("FAIL pre_reset_m1 got st=%0d we=%b exp st=6 we=0", st_b, we_b);
        end
        #2; Resetn = 1'b0; #1;
        n_checks++;
        if ({st_b, we_b, init_b, en_b, m2s_b, m1s_b, vga_b, err_b, addr_b} !==
            {3'd0, 1'b1, 4'b0, 1'b1, 1'b0, vga_address_i}) begin
            n_bad++;
            $display("FAIL async_reset got st=%0d we=%b pulses=%b vga=%b err=%b exp st=0 we=1 pulses=0000 vga=1 err=0",
                     st_b, we_b, {init_b, en_b, m2s_b, m1s_b}, vga_b, err_b);
        end
        tick();
        Resetn = 1'b1; m1_we_n_i = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout checks=%0d", n_checks);
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        test_reset();
        test_uart_load();
        test_uart_no_write();
        test_skip_sequence();
        test_watchdog();
        test_finish_vs_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
